// File: rtl/lorenz_pkg.sv
// lorenz_pkg: shared types and constants for the Lorenz stream generator.
// Optional feature macro: LORENZ_SAT_EN (saturating arithmetic, sat_flag port).
package lorenz_pkg;

   // Default Q16.16 format
   localparam int unsigned LZ_W    = 32;
   localparam int unsigned LZ_FRAC = 16;

   typedef logic signed [LZ_W-1:0] q_t;

   // Largest positive value of a w-bit signed word (w <= 64)
   function automatic logic [63:0] lz_max(input int unsigned w);
      lz_max = (64'd1 << (w - 1)) - 64'd1;
   endfunction

   localparam q_t Q_ONE = q_t'(64'd1 << LZ_FRAC);
   localparam q_t Q_MAX = q_t'(lz_max(LZ_W));
   localparam q_t Q_MIN = ~Q_MAX;

   typedef enum logic [2:0] {
      S_IDLE,
      S_M1,
      S_M2,
      S_M3,
      S_M4,
      S_UPD,
      S_OUT
   } lz_state_e;

endpackage

// File: rtl/lorenz_fx_mul.sv
// lorenz_fx_mul: combinational signed W x W fixed-point multiply, full
// 2W-bit product rescaled by >>> FRAC. With LORENZ_SAT_EN the result clamps
// to the signed W-bit range and sat_o flags the clamp; otherwise it wraps.
module lorenz_fx_mul
   import lorenz_pkg::*;
#(
   parameter int unsigned W    = LZ_W,
   parameter int unsigned FRAC = LZ_FRAC
) (
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   output logic signed [W-1:0] p_o
`ifdef LORENZ_SAT_EN
   ,
   output logic                sat_o
`endif
);

   logic signed [2*W-1:0] full;

   // Full-precision signed product
   always_comb begin
      full = (2*W)'(a_i) * (2*W)'(b_i);
   end

`ifdef LORENZ_SAT_EN
   localparam logic signed [W-1:0] PMAX = W'(lz_max(W));
   localparam logic signed [W-1:0] PMIN = ~PMAX;

   logic signed [2*W-1:0] scaled;

   // Rescale and clamp to the W-bit signed range
   always_comb begin
      scaled = full >>> FRAC;
      sat_o  = 1'b0;
      p_o    = scaled[W-1:0];
      if (scaled > (2*W)'(PMAX)) begin
         p_o   = PMAX;
         sat_o = 1'b1;
      end else if (scaled < (2*W)'(PMIN)) begin
         p_o   = PMIN;
         sat_o = 1'b1;
      end
   end
`else
   // Rescale and wrap modulo 2^W
   always_comb begin
      p_o = W'(full >>> FRAC);
   end
`endif

endmodule

// File: rtl/lorenz_stream_gen.sv
// lorenz_stream_gen: fixed-point Lorenz attractor stepped by forward Euler,
// one shared multiplier over M1..M4, seed load, warm-up discard and a
// valid/ready output stream held stable under backpressure.
// Optional feature macro: LORENZ_SAT_EN (saturating products and state sums,
// sticky sat_flag output).
module lorenz_stream_gen
   import lorenz_pkg::*;
#(
   parameter int unsigned W        = LZ_W,
   parameter int unsigned FRAC     = LZ_FRAC,
   parameter int unsigned DT_SHIFT = 8,
   parameter int unsigned WARMUP   = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic signed [W-1:0] sigma,
   input  logic signed [W-1:0] rho,
   input  logic signed [W-1:0] beta,
   input  logic                seed_valid,
   input  logic signed [W-1:0] seed_x,
   input  logic signed [W-1:0] seed_y,
   input  logic signed [W-1:0] seed_z,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_x,
   output logic signed [W-1:0] out_y,
   output logic signed [W-1:0] out_z,
   output logic                busy,
   output logic                warm_done
`ifdef LORENZ_SAT_EN
   ,
   output logic                sat_flag
`endif
);

   localparam int unsigned          CW       = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
   localparam logic [CW-1:0]        WARM_MAX = CW'(WARMUP);
   localparam logic signed [W-1:0]  ONE      = W'(64'd1 << FRAC);

   lz_state_e             state_q;
   logic signed [W-1:0]   x_q, y_q, z_q;
   logic signed [W-1:0]   sigma_q, rho_q, beta_q;
   logic signed [W-1:0]   p1_q, p2_q, p3_q, p4_q;
   logic [CW-1:0]         cnt_q;
   logic                  out_valid_q, busy_q, warm_done_q;
   logic signed [W-1:0]   out_x_q, out_y_q, out_z_q;

   logic signed [W-1:0]   mul_a, mul_b, mul_p;
   logic signed [W-1:0]   dy, dz, stx, sty, stz;
   logic signed [W-1:0]   x_d, y_d, z_d;

`ifdef LORENZ_SAT_EN
   localparam logic signed [W-1:0] SMAX = W'(lz_max(W));
   localparam logic signed [W-1:0] SMIN = ~SMAX;

   logic                  mul_sat, sum_sat, sat_q;
   logic [W:0]            rx, ry, rz;

   // Bit W carries the clamp indication, bits W-1:0 the clamped sum
   function automatic logic [W:0] add_sat(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
      logic signed [W:0] s;
      s = {a[W-1], a} + {b[W-1], b};
      if (s[W] != s[W-1]) begin
         add_sat = {1'b1, (s[W] ? SMIN : SMAX)};
      end else begin
         add_sat = {1'b0, s[W-1:0]};
      end
   endfunction
`endif

   // Operand selection for the shared multiplier; all use pre-iteration state
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         S_M1: begin mul_a = sigma_q; mul_b = y_q - x_q;   end
         S_M2: begin mul_a = x_q;     mul_b = rho_q - z_q; end
         S_M3: begin mul_a = x_q;     mul_b = y_q;         end
         S_M4: begin mul_a = beta_q;  mul_b = z_q;         end
         default: ;
      endcase
   end

   lorenz_fx_mul #(
      .W    (W),
      .FRAC (FRAC)
   ) u_mul (
      .a_i   (mul_a),
      .b_i   (mul_b),
      .p_o   (mul_p)
`ifdef LORENZ_SAT_EN
      ,
      .sat_o (mul_sat)
`endif
   );

   // Euler step: derivatives from the stored products, scaled by dt
   always_comb begin
      dy  = p2_q - y_q;
      dz  = p3_q - p4_q;
      stx = p1_q >>> DT_SHIFT;
      sty = dy >>> DT_SHIFT;
      stz = dz >>> DT_SHIFT;
`ifdef LORENZ_SAT_EN
      rx      = add_sat(x_q, stx);
      ry      = add_sat(y_q, sty);
      rz      = add_sat(z_q, stz);
      x_d     = rx[W-1:0];
      y_d     = ry[W-1:0];
      z_d     = rz[W-1:0];
      sum_sat = rx[W] | ry[W] | rz[W];
`else
      x_d = x_q + stx;
      y_d = y_q + sty;
      z_d = z_q + stz;
`endif
   end

   // Iteration FSM with registered stream outputs; seed load overrides all.
   // warm_done is refreshed at each iteration boundary so it rises together
   // with the first delivered beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         x_q         <= ONE;
         y_q         <= ONE;
         z_q         <= ONE;
         sigma_q     <= '0;
         rho_q       <= '0;
         beta_q      <= '0;
         p1_q        <= '0;
         p2_q        <= '0;
         p3_q        <= '0;
         p4_q        <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         warm_done_q <= (WARMUP == 0);
         out_x_q     <= '0;
         out_y_q     <= '0;
         out_z_q     <= '0;
`ifdef LORENZ_SAT_EN
         sat_q       <= 1'b0;
`endif
      end else if (seed_valid) begin
         state_q     <= S_IDLE;
         x_q         <= seed_x;
         y_q         <= seed_y;
         z_q         <= seed_z;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         warm_done_q <= (WARMUP == 0);
`ifdef LORENZ_SAT_EN
         sat_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (run) begin
                  state_q <= S_M1;
                  sigma_q <= sigma;
                  rho_q   <= rho;
                  beta_q  <= beta;
                  busy_q  <= 1'b1;
               end
            end
            S_M1: begin p1_q <= mul_p; state_q <= S_M2;  end
            S_M2: begin p2_q <= mul_p; state_q <= S_M3;  end
            S_M3: begin p3_q <= mul_p; state_q <= S_M4;  end
            S_M4: begin p4_q <= mul_p; state_q <= S_UPD; end
            S_UPD: begin
               x_q         <= x_d;
               y_q         <= y_d;
               z_q         <= z_d;
               warm_done_q <= (cnt_q == WARM_MAX);
               if (cnt_q >= WARM_MAX) begin
                  state_q     <= S_OUT;
                  out_valid_q <= 1'b1;
                  out_x_q     <= x_d;
                  out_y_q     <= y_d;
                  out_z_q     <= z_d;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (run) begin
                     state_q <= S_M1;
                     sigma_q <= sigma;
                     rho_q   <= rho;
                     beta_q  <= beta;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (run) begin
                     state_q <= S_M1;
                     sigma_q <= sigma;
                     rho_q   <= rho;
                     beta_q  <= beta;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
`ifdef LORENZ_SAT_EN
         if (((state_q inside {S_M1, S_M2, S_M3, S_M4}) && mul_sat) ||
             ((state_q == S_UPD) && sum_sat)) begin
            sat_q <= 1'b1;
         end
`endif
      end
   end

   // Registered outputs to ports
   always_comb begin
      out_valid = out_valid_q;
      out_x     = out_x_q;
      out_y     = out_y_q;
      out_z     = out_z_q;
      busy      = busy_q;
      warm_done = warm_done_q;
`ifdef LORENZ_SAT_EN
      sat_flag  = sat_q;
`endif
   end

endmodule

// File: tb/tb_lorenz_stream_gen.sv
// tb_lorenz_stream_gen: directed bench for lorenz_stream_gen, one instance
// with WARMUP=0 and one with WARMUP=4. Expected values are hand-derived Q16.16.
// Build with or without LORENZ_SAT_EN.
module tb_lorenz_stream_gen;
   import lorenz_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] sigma, rho, beta, sx, sy, sz;
   logic        run0, ready0, seed0, run4, ready4, seed4;
   logic        v0, b0, wd0, v4, b4, wd4;
   logic [31:0] x0, y0, z0, x4, y4, z4;
`ifdef LORENZ_SAT_EN
   logic        sf0, sf4;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int n;
   logic wd_prev;

   always #5 clk = ~clk;

   lorenz_stream_gen #(.W(32), .FRAC(16), .DT_SHIFT(8), .WARMUP(0)) dut0 (
      .clk(clk), .reset(reset), .run(run0),
      .sigma(sigma), .rho(rho), .beta(beta),
      .seed_valid(seed0), .seed_x(sx), .seed_y(sy), .seed_z(sz),
      .out_valid(v0), .out_ready(ready0),
      .out_x(x0), .out_y(y0), .out_z(z0),
      .busy(b0), .warm_done(wd0)
`ifdef LORENZ_SAT_EN
      , .sat_flag(sf0)
`endif
   );

   lorenz_stream_gen #(.W(32), .FRAC(16), .DT_SHIFT(8), .WARMUP(4)) dut4 (
      .clk(clk), .reset(reset), .run(run4),
      .sigma(sigma), .rho(rho), .beta(beta),
      .seed_valid(seed4), .seed_x(sx), .seed_y(sy), .seed_z(sz),
      .out_valid(v4), .out_ready(ready4),
      .out_x(x4), .out_y(y4), .out_z(z4),
      .busy(b4), .warm_done(wd4)
`ifdef LORENZ_SAT_EN
      , .sat_flag(sf4)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Counts clock edges until out_valid is seen, bounded by limit
   task automatic wait_valid(input bit sel4, input int limit, output int cnt);
      logic v;
      cnt = 0;
      do begin
         tick();
         cnt++;
         v = sel4 ? v4 : v0;
      end while (!v && cnt < limit);
      if (!v) chk("valid_timeout", {31'd0, v}, 32'd1);
   endtask

   initial begin
      reset  = 1'b1;
      sigma  = 32'h000A0000;
      rho    = 32'h001C0000;
      beta   = 32'h0002AAAB;
      sx = '0; sy = '0; sz = '0;
      run0 = 1'b0; ready0 = 1'b0; seed0 = 1'b0;
      run4 = 1'b0; ready4 = 1'b0; seed4 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      tick();

      // Reset state
      chk("rst_valid", {31'd0, v0}, 32'd0);
      chk("rst_x", x0, 32'd0);
      chk("rst_y", y0, 32'd0);
      chk("rst_z", z0, 32'd0);
      chk("rst_busy", {31'd0, b0}, 32'd0);
      chk("rst_warm0", {31'd0, wd0}, 32'd1);
      chk("rst_warm4", {31'd0, wd4}, 32'd0);

      // First iteration from (1,1,1), held under backpressure
      run0 = 1'b1;
      ready0 = 1'b0;
      wait_valid(1'b0, 20, n);
      chk("first_lat", 32'(n), 32'd6);
      chk("b1_x", x0, 32'h00010000);
      chk("b1_y", y0, 32'h00011A00);
      chk("b1_z", z0, 32'h0000FE55);
      chk("b1_warm", {31'd0, wd0}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("bp_valid", {31'd0, v0}, 32'd1);
         chk("bp_busy", {31'd0, b0}, 32'd1);
         chk("bp_x", x0, 32'h00010000);
         chk("bp_y", y0, 32'h00011A00);
         chk("bp_z", z0, 32'h0000FE55);
      end

      // Release: one beat accepted, next beat six cycles later
      ready0 = 1'b1;
      wait_valid(1'b0, 20, n);
      chk("b2_gap", 32'(n), 32'd6);
      chk("b2_x", x0, 32'h00010104);
      chk("b2_y", y0, 32'h000133E7);
      chk("b2_z", z0, 32'h0000FCC8);

      // Run dropped during M2 of the following iteration
      tick();
      tick();
      run0 = 1'b0;
      wait_valid(1'b0, 20, n);
      chk("rundrop_lat", 32'(n), 32'd4);
      tick();
      chk("rundrop_valid", {31'd0, v0}, 32'd0);
      chk("rundrop_busy", {31'd0, b0}, 32'd0);
      repeat (4) tick();
      chk("rundrop_idle", {31'd0, b0}, 32'd0);

      // Seed (2,3,4) pulsed during M3
      run0 = 1'b1;
      tick();
      tick();
      tick();
      sx = Q_ONE <<< 1;
      sy = Q_ONE + (Q_ONE <<< 1);
      sz = Q_ONE <<< 2;
      seed0 = 1'b1;
      tick();
      seed0 = 1'b0;
      chk("seed_valid_drop", {31'd0, v0}, 32'd0);
      chk("seed_idle", {31'd0, b0}, 32'd0);
      wait_valid(1'b0, 20, n);
      chk("seed_lat", 32'(n), 32'd6);
      chk("seed_x", x0, 32'h00020A00);
      chk("seed_y", y0, 32'h00032D00);
      chk("seed_z", z0, 32'h0003FB55);
      run0 = 1'b0;
      tick();
      chk("seed_after_busy", {31'd0, b0}, 32'd0);

      // Large seed: products overflow the W-bit range
`ifdef LORENZ_SAT_EN
      chk("sat_clear0", {31'd0, sf0}, 32'd0);
`endif
      sx = 32'h7FFF0000;
      sy = 32'h7FFF0000;
      sz = 32'h00000000;
      seed0 = 1'b1;
      tick();
      seed0 = 1'b0;
      run0 = 1'b1;
      wait_valid(1'b0, 20, n);
      run0 = 1'b0;
      chk("ovf_lat", 32'(n), 32'd6);
      chk("ovf_x", x0, 32'h7FFF0000);
`ifdef LORENZ_SAT_EN
      chk("sat_y", y0, 32'h7FFF00FF);
      chk("sat_z", z0, 32'h007FFFFF);
      chk("sat_flag_set", {31'd0, sf0}, 32'd1);
      tick();
      seed0 = 1'b1;
      tick();
      seed0 = 1'b0;
      chk("sat_flag_seed_clr", {31'd0, sf0}, 32'd0);
`else
      chk("wrap_y", y0, 32'h807EE500);
      chk("wrap_z", z0, 32'h00000100);
      tick();
`endif

      // Warm-up of four discarded iterations on the second instance
      run4 = 1'b1;
      ready4 = 1'b1;
      n = 0;
      do begin
         wd_prev = wd4;
         tick();
         n++;
      end while (!v4 && n < 100);
      chk("warm_lat", 32'(n), 32'd26);
      chk("warm_done_rise", {31'd0, wd4}, 32'd1);
      chk("warm_done_before", {31'd0, wd_prev}, 32'd0);

      // Seed coincident with the OUT handshake restarts the warm-up
      sx = Q_ONE <<< 1;
      sy = Q_ONE + (Q_ONE <<< 1);
      sz = Q_ONE <<< 2;
      seed4 = 1'b1;
      tick();
      seed4 = 1'b0;
      chk("w4_seed_valid", {31'd0, v4}, 32'd0);
      chk("w4_seed_warm", {31'd0, wd4}, 32'd0);
      chk("w4_seed_busy", {31'd0, b4}, 32'd0);
      wait_valid(1'b1, 100, n);
      chk("w4_relat", 32'(n), 32'd26);
      chk("w4_rewarm", {31'd0, wd4}, 32'd1);
      run4 = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
